// File: rtl/byte_rx_if.sv
// Serial-line receiver bus: the line input plus the decoded byte, strobe and
// status pulses. The master side drives the serial line; the slave side is the
// receiver. The optional parity checker is enabled with BYTE_RX_PARITY_EN.
interface byte_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       en;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rxd,
        input  data,
        input  en,
        input  busy,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rxd,
        output data,
        output en,
        output busy,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/byte_rx.sv
// byte_rx: 8N1 LSB-first serial byte receiver feeding the data/en control FSM.
// The line is double-flopped, then a single FSM times the samples off a
// per-bit cycle counter. Defining BYTE_RX_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit (8E1 framing).
module byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input logic      clk,
    input logic      rst_n,
    byte_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    logic             rxdMeta_q;
    logic             rxdSync_q;
    state_t           state_q;
    logic [CNT_W-1:0] cycleCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             en_q;
    logic             busy_q;
    logic             frameErr_q;
`ifdef BYTE_RX_PARITY_EN
    logic             parityErr_q;
    logic             parityBad_q;
`endif

    logic [CNT_W-1:0] cycleCnt_d;
    logic [7:0]       shift_d;

    assign cycleCnt_d = cycleCnt_q + 1'b1;
    assign shift_d    = {rxdSync_q, shift_q[7:1]};

    // Two-flop synchroniser; resets to the idle (high) line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= bus.rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    // Frame FSM: times samples from the start edge, assembles the byte and
    // registers the strobe and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cycleCnt_q  <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef BYTE_RX_PARITY_EN
            parityErr_q <= 1'b0;
            parityBad_q <= 1'b0;
`endif
        end else begin
            en_q        <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef BYTE_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cycleCnt_q <= '0;
                    if (!rxdSync_q) begin
                        state_q     <= START;
                        busy_q      <= 1'b1;
`ifdef BYTE_RX_PARITY_EN
                        parityBad_q <= 1'b0;
`endif
                    end
                end

                START: begin
                    if (cycleCnt_q == HALF_LAST) begin
                        cycleCnt_q <= '0;
                        if (rxdSync_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= DATA;
                            bitIdx_q <= '0;
                        end
                    end else begin
                        cycleCnt_q <= cycleCnt_d;
                    end
                end

                DATA: begin
                    if (cycleCnt_q == FULL_LAST) begin
                        cycleCnt_q <= '0;
                        shift_q    <= shift_d;
                        bitIdx_q   <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
`ifdef BYTE_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cycleCnt_q <= cycleCnt_d;
                    end
                end

`ifdef BYTE_RX_PARITY_EN
                PARITY: begin
                    if (cycleCnt_q == FULL_LAST) begin
                        cycleCnt_q  <= '0;
                        parityBad_q <= ^{shift_q, rxdSync_q};
                        parityErr_q <= ^{shift_q, rxdSync_q};
                        state_q     <= STOP;
                    end else begin
                        cycleCnt_q <= cycleCnt_d;
                    end
                end
`endif

                STOP: begin
                    if (cycleCnt_q == FULL_LAST) begin
                        cycleCnt_q <= '0;
                        if (rxdSync_q) begin
`ifdef BYTE_RX_PARITY_EN
                            if (!parityBad_q) begin
                                data_q <= shift_q;
                                en_q   <= 1'b1;
                            end
`else
                            data_q <= shift_q;
                            en_q   <= 1'b1;
`endif
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end else begin
                        cycleCnt_q <= cycleCnt_d;
                    end
                end

                BREAK: begin
                    cycleCnt_q <= '0;
                    if (rxdSync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    cycleCnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frameErr_q;
`ifdef BYTE_RX_PARITY_EN
    assign bus.parity_err = parityErr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_rx.sv
// Testbench for byte_rx. Frames are driven on the serial line cycle by cycle;
// a frame-level reference model predicts which bytes and errors must appear.
// Build with BYTE_RX_PARITY_EN defined to exercise the parity variant.
module tb_byte_rx;

    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    localparam int SYNC_LAT = 2;
`ifdef BYTE_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int STOP_OFS  = HALF + (PAR_ON ? 10 : 9) * CPB;
    localparam int FRAME_LEN = (PAR_ON ? 11 : 10) * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    byte_rx_if busIf ();

    byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Cycle stamp used by the monitor and timing checks.
    always @(posedge clk) cycle <= cycle + 1;

    int         enCyc[$];
    logic [7:0] enVal[$];
    int         feCount    = 0;
    int         peTotal    = 0;
    int         violations = 0;
    int         busyGaps   = 0;
    int         winLo      = 32'h7fff_ffff;
    int         winHi      = 0;
    logic       prevEn     = 1'b0;
    logic       prevFe     = 1'b0;
    logic       prevPe     = 1'b0;
    logic [7:0] prevData   = 8'h00;

    // Output monitor: logs strobes and pulses, and counts protocol invariant
    // breaches and busy drops inside a requested window.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busIf.en === 1'b1) begin
                enCyc.push_back(cycle);
                enVal.push_back(busIf.data);
            end
            if (busIf.frame_err === 1'b1) feCount <= feCount + 1;
            if (busIf.parity_err === 1'b1) peTotal <= peTotal + 1;
            if (($countones({busIf.en, busIf.frame_err, busIf.parity_err}) > 1)
                || (busIf.en && prevEn) || (busIf.frame_err && prevFe)
                || (busIf.parity_err && prevPe)
                || (!busIf.en && busIf.data !== prevData))
                violations <= violations + 1;
            if (cycle >= winLo && cycle <= winHi && busIf.busy !== 1'b1)
                busyGaps <= busyGaps + 1;
        end
        prevEn   <= busIf.en;
        prevFe   <= busIf.frame_err;
        prevPe   <= busIf.parity_err;
        prevData <= busIf.data;
    end

    // Reference model state: bytes that must be delivered and error totals.
    logic [7:0] expBytes[$];
    int         expFeTotal = 0;
    int         expPeTotal = 0;
    int         lastFall   = 0;

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic holdLine(input logic v, input int n);
        busIf.rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveFrame(input logic [7:0] b, input logic stopBit, input logic badParity);
        lastFall = cycle;
        holdLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdLine(b[i], CPB);
`ifdef BYTE_RX_PARITY_EN
        holdLine((^b) ^ badParity, CPB);
`endif
        holdLine(stopBit, CPB);
        if (stopBit && !(PAR_ON && badParity)) expBytes.push_back(b);
        if (!stopBit) expFeTotal++;
        if (PAR_ON && badParity) expPeTotal++;
    endtask

    task automatic test_reset();
        busIf.rxd = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busIf.data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 00", busIf.data); end
        checks++; if (busIf.en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b, expected 0", busIf.en); end
        checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busIf.busy); end
        checks++; if (busIf.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", busIf.frame_err); end
        checks++; if (busIf.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err: got %b, expected 0", busIf.parity_err); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        holdLine(1'b1, 5);
    endtask

    task automatic test_single_byte();
        int base;
        int busyBase;
        int expCyc;
        logic [7:0] got;
        base = enCyc.size();
        busyBase = busyGaps;
        expBytes.delete();
        winLo = cycle + SYNC_LAT + 2;
        winHi = cycle + SYNC_LAT + STOP_OFS - 1;
        driveFrame(8'hA5, 1'b1, 1'b0);
        holdLine(1'b1, 20);
        winLo = 32'h7fff_ffff;
        expCyc = lastFall + SYNC_LAT + STOP_OFS + 1;
        checks++; if (enCyc.size() - base != 1) begin errors++; $display("[TB] FAIL single_en_count: got %0d, expected 1", enCyc.size() - base); end
        got = (enVal.size() > base) ? enVal[base] : 8'hxx;
        checks++; if (got !== 8'hA5) begin errors++; $display("[TB] FAIL single_en_data: got %h, expected a5", got); end
        checks++;
        if (enCyc.size() <= base || enCyc[base] < expCyc - 1 || enCyc[base] > expCyc + 1) begin
            errors++;
            $display("[TB] FAIL single_latency: got cycle %0d, expected %0d +/-1", (enCyc.size() > base) ? enCyc[base] : -1, expCyc);
        end
        checks++; if (busIf.data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_hold: got %h, expected a5", busIf.data); end
        checks++; if (busyGaps != busyBase) begin errors++; $display("[TB] FAIL single_busy: got %0d low cycles, expected 0", busyGaps - busyBase); end
    endtask

    task automatic test_random_bytes();
        int base;
        int feBase;
        int expFeBase;
        int n;
        logic [7:0] b;
        logic stopBit;
        int gap;
        base = enCyc.size();
        feBase = feCount;
        expFeBase = expFeTotal;
        expBytes.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            stopBit = ($urandom_range(0, 4) != 0);
            driveFrame(b, stopBit, 1'b0);
            gap = stopBit ? $urandom_range(0, 20) : $urandom_range(4, 20);
            if (gap > 0) holdLine(1'b1, gap);
            else busIf.rxd = 1'b1;
        end
        holdLine(1'b1, 20);
        n = enCyc.size() - base;
        checks++; if (n != expBytes.size()) begin errors++; $display("[TB] FAIL random_count: got %0d, expected %0d", n, expBytes.size()); end
        for (int i = 0; i < expBytes.size(); i++) begin
            checks++;
            if (i >= n || enVal[base + i] !== expBytes[i]) begin
                errors++;
                $display("[TB] FAIL random_byte%0d: got %h, expected %h", i, (i < n) ? enVal[base + i] : 8'hxx, expBytes[i]);
            end
        end
        checks++; if (feCount - feBase != expFeTotal - expFeBase) begin errors++; $display("[TB] FAIL random_frame_err: got %0d, expected %0d", feCount - feBase, expFeTotal - expFeBase); end
    endtask

    task automatic test_back_to_back();
        int base;
        int feBase;
        int n;
        base = enCyc.size();
        feBase = feCount;
        driveFrame(8'h0F, 1'b1, 1'b0);
        driveFrame(8'hF0, 1'b1, 1'b0);
        holdLine(1'b1, 20);
        n = enCyc.size() - base;
        checks++; if (n != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d, expected 2", n); end
        checks++; if (n < 1 || enVal[base] !== 8'h0F) begin errors++; $display("[TB] FAIL b2b_first: got %h, expected 0f", (n > 0) ? enVal[base] : 8'hxx); end
        checks++; if (n < 2 || enVal[base + 1] !== 8'hF0) begin errors++; $display("[TB] FAIL b2b_second: got %h, expected f0", (n > 1) ? enVal[base + 1] : 8'hxx); end
        checks++; if (n < 2 || enCyc[base + 1] - enCyc[base] != FRAME_LEN) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", (n > 1) ? enCyc[base + 1] - enCyc[base] : -1, FRAME_LEN); end
        checks++; if (feCount != feBase) begin errors++; $display("[TB] FAIL b2b_frame_err: got %0d, expected 0", feCount - feBase); end
    endtask

    task automatic test_false_start();
        int base;
        int feBase;
        int fall;
        int busyFall;
        int expFall;
        logic [7:0] prev;
        base = enCyc.size();
        feBase = feCount;
        prev = busIf.data;
        fall = cycle;
        busyFall = -1;
        holdLine(1'b0, 4);
        busIf.rxd = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busyFall < 0 && cycle > fall + SYNC_LAT + 1 && busIf.busy === 1'b0) busyFall = cycle;
        end
        @(posedge clk); #1;
        expFall = fall + SYNC_LAT + 1 + HALF;
        checks++; if (busyFall < expFall - 1 || busyFall > expFall + 1) begin errors++; $display("[TB] FAIL false_busy_fall: got cycle %0d, expected %0d +/-1", busyFall, expFall); end
        checks++; if (enCyc.size() != base) begin errors++; $display("[TB] FAIL false_en: got %0d strobes, expected 0", enCyc.size() - base); end
        checks++; if (feCount != feBase) begin errors++; $display("[TB] FAIL false_frame_err: got %0d, expected 0", feCount - feBase); end
        checks++; if (busIf.data !== prev) begin errors++; $display("[TB] FAIL false_data: got %h, expected %h", busIf.data, prev); end
    endtask

    task automatic test_frame_error();
        int base;
        int feBase;
        int busyBase;
        int n;
        logic [7:0] r;
        r = 8'($urandom);
        driveFrame(r, 1'b1, 1'b0);
        holdLine(1'b1, 10);
        base = enCyc.size();
        feBase = feCount;
        busyBase = busyGaps;
        driveFrame(8'h3C, 1'b0, 1'b0);
        winLo = cycle;
        winHi = cycle + 49;
        holdLine(1'b0, 50);
        winLo = 32'h7fff_ffff;
        holdLine(1'b1, 20);
        checks++; if (busIf.data !== r) begin errors++; $display("[TB] FAIL ferr_data_kept: got %h, expected %h", busIf.data, r); end
        checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_idle_after: got %b, expected 0", busIf.busy); end
        checks++; if (busyGaps != busyBase) begin errors++; $display("[TB] FAIL ferr_break_busy: got %0d low cycles, expected 0", busyGaps - busyBase); end
        checks++; if (feCount - feBase != 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d, expected 1", feCount - feBase); end
        checks++; if (enCyc.size() != base) begin errors++; $display("[TB] FAIL ferr_no_en: got %0d strobes, expected 0", enCyc.size() - base); end
        driveFrame(8'h11, 1'b1, 1'b0);
        holdLine(1'b1, 20);
        n = enCyc.size() - base;
        checks++; if (n != 1 || enVal[base] !== 8'h11) begin errors++; $display("[TB] FAIL ferr_recover: got %0d strobes data %h, expected 1 strobe data 11", n, (n > 0) ? enVal[base] : 8'hxx); end
    endtask

    task automatic test_reset_midframe();
        int base;
        int n;
        logic [7:0] b;
        b = 8'h5A;
        holdLine(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdLine(b[i], CPB);
        busIf.rxd = b[4];
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busIf.data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h, expected 00", busIf.data); end
        checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busIf.busy); end
        checks++; if ({busIf.en, busIf.frame_err, busIf.parity_err} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_pulses: got %b, expected 000", {busIf.en, busIf.frame_err, busIf.parity_err}); end
        busIf.rxd = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        holdLine(1'b1, 5);
        base = enCyc.size();
        driveFrame(b, 1'b1, 1'b0);
        holdLine(1'b1, 20);
        n = enCyc.size() - base;
        checks++; if (n != 1 || enVal[base] !== 8'h5A) begin errors++; $display("[TB] FAIL midrst_recover: got %0d strobes data %h, expected 1 strobe data 5a", n, (n > 0) ? enVal[base] : 8'hxx); end
    endtask

`ifdef BYTE_RX_PARITY_EN
    task automatic test_parity();
        int base;
        int peBase;
        int n;
        base = enCyc.size();
        peBase = peTotal;
        driveFrame(8'h03, 1'b1, 1'b0);
        holdLine(1'b1, 10);
        n = enCyc.size() - base;
        checks++; if (n != 1 || enVal[base] !== 8'h03) begin errors++; $display("[TB] FAIL parity_good: got %0d strobes data %h, expected 1 strobe data 03", n, (n > 0) ? enVal[base] : 8'hxx); end
        base = enCyc.size();
        driveFrame(8'h03, 1'b1, 1'b1);
        holdLine(1'b1, 10);
        checks++; if (peTotal - peBase != 1) begin errors++; $display("[TB] FAIL parity_err_count: got %0d, expected 1", peTotal - peBase); end
        checks++; if (enCyc.size() != base) begin errors++; $display("[TB] FAIL parity_no_en: got %0d strobes, expected 0", enCyc.size() - base); end
        checks++; if (busIf.data !== 8'h03) begin errors++; $display("[TB] FAIL parity_data_kept: got %h, expected 03", busIf.data); end
    endtask
`endif

    task automatic test_invariants();
        checks++; if (violations != 0) begin errors++; $display("[TB] FAIL invariants: got %0d breaches, expected 0", violations); end
        checks++; if (peTotal != expPeTotal) begin errors++; $display("[TB] FAIL parity_total: got %0d, expected %0d", peTotal, expPeTotal); end
        checks++; if (feCount != expFeTotal) begin errors++; $display("[TB] FAIL frame_err_total: got %0d, expected %0d", feCount, expFeTotal); end
    endtask

    // Test sequence.
    initial begin
        busIf.rxd = 1'b1;
        test_reset();
        test_single_byte();
        test_random_bytes();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_midframe();
`ifdef BYTE_RX_PARITY_EN
        test_parity();
`endif
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_rx.md
Name: byte_rx

Overview:
- Serial byte receiver, one stage upstream of the data/enable-driven control FSM.
- Deserialises an asynchronous, LSB-first, 8N1 serial line (1 start bit, 8 data bits, 1 stop bit) into `data[7:0]` plus a one-cycle `en` strobe.
- Its outputs connect directly to the FSM's `data` and `en` inputs. Bit timing derives from a fixed clocks-per-bit divisor.

Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be an even number, 4 or greater.
- `HALF_BIT`, default `CLKS_PER_BIT/2`: offset from the start edge to the start-bit sample point. Derived; do not override.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `rxd` input 1: serial line; idle level is 1; asynchronous to clk.
- `data` output 8: last correctly received byte.
- `en` output 1: one-cycle strobe; `data` is valid and updated in that same cycle.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err` output 1: one-cycle pulse on a parity mismatch. Tied to 0 unless `BYTE_RX_PARITY_EN` is defined.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE; `data`=8'h00; `en`=0; `busy`=0; `frame_err`=0; `parity_err`=0.
  - Synchroniser flops=1; bit counter=0; cycle counter=0.
- Synchroniser:
  - `rxd` passes through 2 flops to give `rxd_s`. All decisions use `rxd_s`.
  - Latency from `rxd` pin to `rxd_s` is 2 cycles.
- Cycle counter: counts clk cycles within a bit and clears on every sample point.
- State machine:
  - IDLE: on `rxd_s`=0, go to START with the cycle counter at 0. The cycle on which this happens is t0.
  - START: sample at t0+`HALF_BIT`.
    - Sample=1: false start; return to IDLE with no pulse.
    - Sample=0: go to DATA, bit index=0.
  - DATA: sample every `CLKS_PER_BIT` cycles.
    - Bit i is sampled at t0+`HALF_BIT`+(i+1)*`CLKS_PER_BIT`.
    - Shift right into an internal shift register (LSB first).
    - After bit 7 is sampled, go to STOP (or to PARITY when the feature is enabled).
  - STOP: sample one bit period after the last sample.
    - Sample=1: `data`<=shift register and `en`=1 for the next single cycle; then go to IDLE.
    - Sample=0: `frame_err`=1 for one cycle; `data` unchanged; `en` stays 0; go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. A held-low line must not retrigger a frame.
- Back-to-back frames: the return to IDLE happens mid stop bit. The next start edge is accepted as soon as `rxd_s` falls, with no idle gap required beyond the remaining stop half-bit.
- `en` and the error pulses are registered and mutually exclusive. None of them is ever high for two consecutive cycles.
- `data` holds its value between strobes. It changes only in the cycle where `en` rises.
- Reset mid-frame: everything returns immediately to reset values, with no pulse. The partial frame is discarded.
- `rxd` glitches shorter than `HALF_BIT` cycles that start a frame end as a false start in IDLE, with no outputs.

Optional Feature:
- `BYTE_RX_PARITY_EN` defined:
  - Adds a PARITY state after DATA. It samples one bit period after data bit 7, using even parity over the 8 data bits plus the parity bit.
  - Mismatch: `parity_err` pulses once and the frame continues to STOP. At STOP, `en` is suppressed and `data` is unchanged even if the stop bit is 1. Stop=0 still gives `frame_err`.
  - The stop sample moves to t0+`HALF_BIT`+10*`CLKS_PER_BIT`.
- Not defined: there is no PARITY state, `parity_err` is held at 0, and the frame is 8N1.

Test Plan:
- Reset, then drive 8N1 byte 8'hA5 with `CLKS_PER_BIT`=16 → exactly one `en` pulse, occurring 2+8+9*16+1 cycles after the `rxd` falling edge (±1 cycle bench tolerance); `data`=8'hA5; `busy` high throughout the frame.
- Back-to-back frames 8'h0F then 8'hF0 with no idle gap → two `en` pulses 160 cycles apart; `data`=8'h0F, then 8'hF0; no errors.
- Start low for 4 cycles, then high → `busy` falls at t0+8; no `en`, no `frame_err`; `data` unchanged.
- Frame 8'h3C with stop bit 0, line then held low 50 cycles, then high → one `frame_err` pulse; no `en`; `data` keeps its previous value; no new frame while held low; 8'h11 sent afterwards is received correctly.
- Assert `rst_n`=0 during data bit 4 → all outputs return to reset values asynchronously; the next full frame 8'h5A is received correctly.
- With `BYTE_RX_PARITY_EN` defined: 8'h03 with parity bit 0 → `en`, `data`=8'h03. Same frame with parity bit 1 → `parity_err` pulse, no `en`, `data` unchanged.
